// File: rtl/clause_stream_eval.sv
// Streams a clause as multi-beat sub-clauses and reports SAT / UNIT / CONFLICT / UNRESOLVED.
// Result is registered on the closing beat and held until the consumer accepts it.
module clause_stream_eval #(
    parameter int SUB_W     = 5,
    parameter int VAR_BITS  = 9,
    parameter int MAX_BEATS = 4,
    parameter int ID_BITS   = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_last,
    input  logic [ID_BITS-1:0]        in_clause_id,
    input  logic [SUB_W-1:0]          unassign,
    input  logic [SUB_W-1:0]          clause_mask,
    input  logic [SUB_W*VAR_BITS-1:0] variable,
    input  logic [SUB_W-1:0]          clause_pole,
    input  logic [SUB_W-1:0]          assignment,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [1:0]                status,
    output logic [VAR_BITS-1:0]       implied_variable,
    output logic                      new_assignment,
    output logic [ID_BITS-1:0]        out_clause_id,
    output logic                      overflow
);

    localparam int CNT_W  = $clog2(MAX_BEATS) + 1;
    localparam int OPEN_W = $clog2(SUB_W + 1) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BEATS - 1);

    localparam logic [1:0] ST_UNRES    = 2'b00;
    localparam logic [1:0] ST_SAT      = 2'b01;
    localparam logic [1:0] ST_UNIT     = 2'b10;
    localparam logic [1:0] ST_CONFLICT = 2'b11;

    typedef enum logic {ACCUM, DONE} state_t;
    state_t state, state_next;

    logic                transfer, accept, close;
    logic [CNT_W-1:0]    beat_cnt;
    logic                sat, sat_next;
    logic [1:0]          open_cnt, open_next;
    logic [OPEN_W-1:0]   open_now, open_sum;
    logic                have_first;
    logic [VAR_BITS-1:0] first_var, first_var_next, beat_var;
    logic                first_pole, first_pole_next, beat_pole;
    logic [ID_BITS-1:0]  id_q;
    logic [SUB_W-1:0]    true_slots, open_slots;
    logic [1:0]          res_status;

    // Reset gates the handshakes so nothing is offered or accepted while it is held.
    assign in_ready  = (state == ACCUM) && !reset;
    assign out_valid = (state == DONE) && !reset;
    assign transfer  = in_valid && in_ready;
    assign accept    = out_valid && out_ready;
    assign close     = transfer && (in_last || (beat_cnt == LAST_BEAT));

    always_ff @(posedge clock) begin
        if (reset) state <= ACCUM;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ACCUM: if (close)  state_next = DONE;
            DONE:  if (accept) state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    assign true_slots = clause_mask & ~unassign & ~(assignment ^ clause_pole);
    assign open_slots = clause_mask & unassign;

    // Descending scan so the lowest open slot of the beat is the one that sticks.
    always_comb begin
        open_now  = '0;
        beat_var  = '0;
        beat_pole = 1'b0;
        for (int i = SUB_W - 1; i >= 0; i--) begin
            if (open_slots[i]) begin
                beat_var  = variable[i*VAR_BITS +: VAR_BITS];
                beat_pole = clause_pole[i];
            end
        end
        for (int i = 0; i < SUB_W; i++) begin
            open_now = open_now + OPEN_W'(open_slots[i]);
        end
    end

    always_comb begin
        sat_next        = sat | (|true_slots);
        open_sum        = OPEN_W'(open_cnt) + open_now;
        open_next       = (open_sum >= OPEN_W'(2)) ? 2'd2 : open_sum[1:0];
        first_var_next  = have_first ? first_var  : beat_var;
        first_pole_next = have_first ? first_pole : beat_pole;
        if (sat_next)             res_status = ST_SAT;
        else if (open_next == 2'd0) res_status = ST_CONFLICT;
        else if (open_next == 2'd1) res_status = ST_UNIT;
        else                      res_status = ST_UNRES;
    end

    always_ff @(posedge clock) begin
        if (reset || accept) begin
            beat_cnt         <= '0;
            sat              <= 1'b0;
            open_cnt         <= 2'd0;
            have_first       <= 1'b0;
            first_var        <= '0;
            first_pole       <= 1'b0;
            id_q             <= '0;
            status           <= ST_UNRES;
            implied_variable <= '0;
            new_assignment   <= 1'b0;
            out_clause_id    <= '0;
            overflow         <= 1'b0;
        end else if (transfer) begin
            beat_cnt   <= beat_cnt + CNT_W'(1);
            sat        <= sat_next;
            open_cnt   <= open_next;
            have_first <= have_first | (|open_slots);
            first_var  <= first_var_next;
            first_pole <= first_pole_next;
            if (beat_cnt == '0) id_q <= in_clause_id;
            if (close) begin
                status           <= res_status;
                implied_variable <= (res_status == ST_UNIT) ? first_var_next : '0;
                new_assignment   <= (res_status == ST_UNIT) ? first_pole_next : 1'b0;
                out_clause_id    <= (beat_cnt == '0) ? in_clause_id : id_q;
                // Closing without in_last can only happen on the beat-limit transfer.
                overflow         <= !in_last;
            end
        end
    end

endmodule

// File: tb/tb_clause_stream_eval.sv
// Directed bench for clause_stream_eval: single-beat vector table plus multi-beat,
// overflow, back-pressure and mid-clause reset sequences.
module tb_clause_stream_eval;

    localparam int SW = 5;
    localparam int VB = 9;
    localparam int MB = 4;
    localparam int IB = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid, in_ready, in_last;
    logic [IB-1:0] in_clause_id;
    logic [SW-1:0] unassign, clause_mask, clause_pole, assignment;
    logic [SW*VB-1:0] variable;
    logic          out_valid, out_ready;
    logic [1:0]    status;
    logic [VB-1:0] implied_variable;
    logic          new_assignment;
    logic [IB-1:0] out_clause_id;
    logic          overflow;

    int tests = 0;
    int failures = 0;

    clause_stream_eval #(.SUB_W(SW), .VAR_BITS(VB), .MAX_BEATS(MB), .ID_BITS(IB)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_clause_id(in_clause_id), .unassign(unassign), .clause_mask(clause_mask),
        .variable(variable), .clause_pole(clause_pole), .assignment(assignment),
        .out_valid(out_valid), .out_ready(out_ready), .status(status),
        .implied_variable(implied_variable), .new_assignment(new_assignment),
        .out_clause_id(out_clause_id), .overflow(overflow)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    typedef struct {
        logic [IB-1:0]    id;
        logic [SW-1:0]    mask, una, asg, pole;
        logic [SW*VB-1:0] vars;
        logic [1:0]       st;
        logic [VB-1:0]    iv;
        logic             na;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [SW*VB-1:0] pk(input logic [VB-1:0] v0, v1, v2, v3, v4);
        return {v4, v3, v2, v1, v0};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid     = 1'b0;
        in_last      = 1'b0;
        in_clause_id = IB'($urandom);
        unassign     = SW'($urandom);
        clause_mask  = SW'($urandom);
        clause_pole  = SW'($urandom);
        assignment   = SW'($urandom);
        variable     = {$urandom, $urandom};
    endtask

    task automatic beat(input logic last, input logic [IB-1:0] id, input logic [SW-1:0] mask,
                        input logic [SW-1:0] una, input logic [SW-1:0] asg,
                        input logic [SW-1:0] pole, input logic [SW*VB-1:0] vars);
        chk("in_ready_before_beat", in_ready, 1);
        in_valid     = 1'b1;
        in_last      = last;
        in_clause_id = id;
        clause_mask  = mask;
        unassign     = una;
        assignment   = asg;
        clause_pole  = pole;
        variable     = vars;
        @(posedge clock); #1;
        idle_inputs();
    endtask

    task automatic check_result(input string name, input logic [1:0] st, input logic [VB-1:0] iv,
                                input logic na, input logic [IB-1:0] id, input logic ov);
        chk({name, "_out_valid"}, out_valid, 1);
        chk({name, "_in_ready"}, in_ready, 0);
        chk({name, "_status"}, status, st);
        chk({name, "_implied_variable"}, implied_variable, iv);
        chk({name, "_new_assignment"}, new_assignment, na);
        chk({name, "_out_clause_id"}, out_clause_id, id);
        chk({name, "_overflow"}, overflow, ov);
    endtask

    task automatic accept_result(input string name);
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        chk({name, "_accept_in_ready"}, in_ready, 1);
        chk({name, "_accept_out_valid"}, out_valid, 0);
    endtask

    initial begin
        vecs[0] = '{8'd7,   5'b00111, 5'b00100, 5'b00010, 5'b00001, pk(0, 0, 42, 0, 0), 2'b10, 9'd42,  1'b0};
        vecs[1] = '{8'd3,   5'b00000, 5'b10101, 5'b11111, 5'b00000, pk(1, 2, 3, 4, 5), 2'b11, 9'd0,   1'b0};
        vecs[2] = '{8'd12,  5'b11111, 5'b00000, 5'b10000, 5'b11111, pk(1, 2, 3, 4, 5), 2'b01, 9'd0,   1'b0};
        vecs[3] = '{8'd33,  5'b11010, 5'b01010, 5'b10000, 5'b00000, pk(1, 2, 3, 4, 5), 2'b00, 9'd0,   1'b0};
        vecs[4] = '{8'd64,  5'b00011, 5'b00010, 5'b00001, 5'b00001, pk(0, 8, 0, 0, 0), 2'b01, 9'd0,   1'b0};
        vecs[5] = '{8'd255, 5'b10000, 5'b11111, 5'b00000, 5'b10000, pk(6, 7, 8, 9, 511), 2'b10, 9'd511, 1'b1};
        vecs[6] = '{8'd128, 5'b11111, 5'b00000, 5'b10101, 5'b01010, pk(1, 2, 3, 4, 5), 2'b11, 9'd0,   1'b0};

        reset     = 1'b1;
        out_ready = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clock);
        #1;
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_status", status, 0);
        chk("reset_implied_variable", implied_variable, 0);
        chk("reset_new_assignment", new_assignment, 0);
        chk("reset_out_clause_id", out_clause_id, 0);
        chk("reset_overflow", overflow, 0);
        reset = 1'b0;
        #1;
        chk("post_reset_in_ready", in_ready, 1);

        for (int i = 0; i < 7; i++) begin
            beat(1'b1, vecs[i].id, vecs[i].mask, vecs[i].una, vecs[i].asg, vecs[i].pole, vecs[i].vars);
            check_result($sformatf("vec%0d", i), vecs[i].st, vecs[i].iv, vecs[i].na, vecs[i].id, 1'b0);
            accept_result($sformatf("vec%0d", i));
        end

        // Two beats, SAT in the second; id must come from the first beat only.
        beat(1'b0, 8'd20, 5'b11111, 5'b00000, 5'b00000, 5'b11111, pk(1, 2, 3, 4, 5));
        chk("two_beat_mid_out_valid", out_valid, 0);
        beat(1'b1, 8'd99, 5'b01000, 5'b00000, 5'b01000, 5'b01000, pk(1, 2, 3, 4, 5));
        check_result("two_beat_sat", 2'b01, 9'd0, 1'b0, 8'd20, 1'b0);
        accept_result("two_beat_sat");

        // Three open slots across three beats saturate to UNRESOLVED.
        beat(1'b0, 8'd40, 5'b00001, 5'b00001, 5'b00000, 5'b00001, pk(5, 0, 0, 0, 0));
        beat(1'b0, 8'd41, 5'b00100, 5'b00100, 5'b00000, 5'b00100, pk(0, 0, 9, 0, 0));
        beat(1'b1, 8'd42, 5'b10000, 5'b10000, 5'b00000, 5'b10000, pk(0, 0, 0, 0, 11));
        check_result("three_open", 2'b00, 9'd0, 1'b0, 8'd40, 1'b0);
        accept_result("three_open");

        beat(1'b0, 8'd50, 5'b00001, 5'b00000, 5'b00000, 5'b00001, pk(5, 0, 0, 0, 0));
        beat(1'b0, 8'd51, 5'b00001, 5'b00000, 5'b00000, 5'b00001, pk(9, 0, 0, 0, 0));
        beat(1'b1, 8'd52, 5'b00001, 5'b00000, 5'b00000, 5'b00001, pk(11, 0, 0, 0, 0));
        check_result("three_false", 2'b11, 9'd0, 1'b0, 8'd50, 1'b0);
        accept_result("three_false");

        // Single open literal in the middle beat of three -> UNIT.
        beat(1'b0, 8'd60, 5'b00011, 5'b00000, 5'b00000, 5'b00011, pk(1, 2, 0, 0, 0));
        beat(1'b0, 8'd61, 5'b01000, 5'b01000, 5'b00000, 5'b01000, pk(0, 0, 0, 77, 0));
        beat(1'b1, 8'd62, 5'b00001, 5'b00000, 5'b00001, 5'b00000, pk(4, 0, 0, 0, 0));
        check_result("mid_unit", 2'b10, 9'd77, 1'b1, 8'd60, 1'b0);
        accept_result("mid_unit");

        // Beat limit without in_last closes with overflow; next beat is a fresh clause.
        for (int b = 0; b < MB; b++) begin
            beat(1'b0, IB'(70 + b), 5'b00001, 5'b00000, 5'b00000, 5'b00001, pk(1, 0, 0, 0, 0));
        end
        check_result("overflow", 2'b11, 9'd0, 1'b0, 8'd70, 1'b1);
        accept_result("overflow");
        beat(1'b1, 8'd80, 5'b00010, 5'b00010, 5'b00000, 5'b00000, pk(0, 300, 0, 0, 0));
        check_result("after_overflow", 2'b10, 9'd300, 1'b0, 8'd80, 1'b0);

        // Back-pressure: result stays put while inputs churn and out_ready is low.
        for (int c = 0; c < 5; c++) begin
            in_valid    = 1'b1;
            in_last     = 1'b1;
            clause_mask = 5'b11111;
            @(posedge clock); #1;
            check_result($sformatf("hold%0d", c), 2'b10, 9'd300, 1'b0, 8'd80, 1'b0);
        end
        idle_inputs();
        accept_result("hold");

        // Reset in the middle of a clause discards it.
        beat(1'b0, 8'd90, 5'b00001, 5'b00001, 5'b00000, 5'b00001, pk(8, 0, 0, 0, 0));
        reset = 1'b1;
        #1;
        chk("midreset_in_ready", in_ready, 0);
        chk("midreset_out_valid", out_valid, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        chk("midreset_after_in_ready", in_ready, 1);
        chk("midreset_after_out_valid", out_valid, 0);
        @(posedge clock); #1;
        chk("midreset_later_out_valid", out_valid, 0);
        beat(1'b1, 8'd9, 5'b00001, 5'b00001, 5'b00000, 5'b00001, pk(3, 0, 0, 0, 0));
        check_result("after_reset_unit", 2'b10, 9'd3, 1'b1, 8'd9, 1'b0);
        accept_result("after_reset_unit");

        // Reset while holding a result drops it.
        beat(1'b1, 8'd11, 5'b00000, 5'b00000, 5'b00000, 5'b00000, pk(0, 0, 0, 0, 0));
        chk("done_reset_pre_out_valid", out_valid, 1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        chk("done_reset_out_valid", out_valid, 0);
        chk("done_reset_status", status, 0);
        chk("done_reset_in_ready", in_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
